// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer, 16 sets, per-set LRU bit.
// Lookup is combinational; writes and LRU updates take effect at the rising edge.
module branch_target_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] new_PC,
  input  logic [29:0] new_target,
  input  logic [1:0]  new_btype,
  input  logic        load,
  input  logic [28:0] fetch_PC,
  output logic [29:0] target,
  output logic [1:0]  btype,
  output logic        hit
);

  logic [15:0] valid0_q, valid0_d;
  logic [15:0] valid1_q, valid1_d;
  // lru_q[s] names the least-recently-used way of set s
  logic [15:0] lru_q, lru_d;
  logic [24:0] tag0_q [16];
  logic [24:0] tag1_q [16];
  logic [31:0] data0_q [16];
  logic [31:0] data1_q [16];

  logic [3:0]  rd_set;
  logic [24:0] rd_tag;
  logic        rd_hit0, rd_hit1;
  logic [31:0] rd_data;

  assign rd_set  = fetch_PC[3:0];
  assign rd_tag  = fetch_PC[28:4];
  assign rd_hit0 = valid0_q[rd_set] && (tag0_q[rd_set] == rd_tag);
  assign rd_hit1 = valid1_q[rd_set] && (tag1_q[rd_set] == rd_tag);

  always_comb begin
    rd_data = '0;
    if (rd_hit0)      rd_data = data0_q[rd_set];
    else if (rd_hit1) rd_data = data1_q[rd_set];
  end

  assign hit             = rd_hit0 | rd_hit1;
  assign {target, btype} = rd_data;

  logic [3:0]  wr_set;
  logic [24:0] wr_tag;
  logic        wr_match0, wr_match1;
  logic        wr_way;

  assign wr_set    = new_PC[3:0];
  assign wr_tag    = new_PC[28:4];
  assign wr_match0 = valid0_q[wr_set] && (tag0_q[wr_set] == wr_tag);
  assign wr_match1 = valid1_q[wr_set] && (tag1_q[wr_set] == wr_tag);

  // Existing key rewrites in place; else first invalid way; else LRU way.
  always_comb begin
    wr_way = lru_q[wr_set];
    if (wr_match0)                 wr_way = 1'b0;
    else if (wr_match1)            wr_way = 1'b1;
    else if (!valid0_q[wr_set])    wr_way = 1'b0;
    else if (!valid1_q[wr_set])    wr_way = 1'b1;
  end

  // Write update is applied last so it wins over a lookup hit in the same set.
  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    lru_d    = lru_q;
    if (hit) lru_d[rd_set] = rd_hit0;
    if (load) begin
      if (wr_way) valid1_d[wr_set] = 1'b1;
      else        valid0_d[wr_set] = 1'b1;
      lru_d[wr_set] = ~wr_way;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !rst) begin
      if (wr_way) begin
        tag1_q[wr_set]  <= wr_tag;
        data1_q[wr_set] <= {new_target, new_btype};
      end else begin
        tag0_q[wr_set]  <= wr_tag;
        data0_q[wr_set] <= {new_target, new_btype};
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [28:0] new_PC = '0;
  logic [29:0] new_target = '0;
  logic [1:0]  new_btype = '0;
  logic        load = 1'b0;
  logic [28:0] fetch_PC = '0;
  logic [29:0] target;
  logic [1:0]  btype;
  logic        hit;

  int checks = 0;
  int errors = 0;

  localparam logic [28:0] KEY_ALT  = 29'b01010101010101010101010101010;
  localparam logic [31:0] VAL_ALT  = 32'h55555555;

  branch_target_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .new_PC     (new_PC),
    .new_target (new_target),
    .new_btype  (new_btype),
    .load       (load),
    .fetch_PC   (fetch_PC),
    .target     (target),
    .btype      (btype),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [28:0] pc, input logic [31:0] d);
    new_PC                  = pc;
    {new_target, new_btype} = d;
    load                    = 1'b1;
    step();
    load                    = 1'b0;
  endtask

  task automatic look(input logic [28:0] pc);
    fetch_PC = pc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    look(29'd0);
    checks++;
    if (hit !== 1'b0 || target !== 30'd0 || btype !== 2'd0) begin
      errors++;
      $display("FAIL reset_pc0: hit=%b target=%h btype=%b, want 0/0/0", hit, target, btype);
    end
    look(KEY_ALT);
    checks++;
    if (hit !== 1'b0 || {target, btype} !== 32'd0) begin
      errors++;
      $display("FAIL reset_alt: hit=%b data=%h, want 0/0", hit, {target, btype});
    end
  endtask

  task automatic test_single_write();
    // Same-key lookup during the write cycle still sees the old contents.
    new_PC                  = KEY_ALT;
    {new_target, new_btype} = VAL_ALT;
    load                    = 1'b1;
    look(KEY_ALT);
    checks++;
    if (hit !== 1'b0 || {target, btype} !== 32'd0) begin
      errors++;
      $display("FAIL write_cycle_lookup: hit=%b data=%h, want 0/0", hit, {target, btype});
    end
    step();
    load = 1'b0;
    look(KEY_ALT);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== VAL_ALT) begin
      errors++;
      $display("FAIL single_write: hit=%b data=%h, want 1/%h", hit, {target, btype}, VAL_ALT);
    end
  endtask

  task automatic test_back_to_back();
    fetch_PC = 29'h1FFF_FFF0;
    for (int k = 0; k < 16; k++) write_key(29'(k), 32'(k));
    for (int k = 0; k < 16; k++) begin
      look(29'(k));
      checks++;
      if (hit !== 1'b1 || {target, btype} !== 32'(k)) begin
        errors++;
        $display("FAIL fill_key%0d: hit=%b data=%h, want 1/%h", k, hit, {target, btype}, 32'(k));
      end
      step();
    end
    look(KEY_ALT);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== VAL_ALT) begin
      errors++;
      $display("FAIL alt_other_way: hit=%b data=%h, want 1/%h", hit, {target, btype}, VAL_ALT);
    end
  endtask

  task automatic test_lru_evict();
    logic [28:0] ka, kb, kc;
    ka = {25'h1, 4'h5};
    kb = {25'h2, 4'h5};
    kc = {25'h3, 4'h5};
    do_reset();
    fetch_PC = 29'h0;
    write_key(ka, 32'hA000_0001);
    write_key(kb, 32'hB000_0002);
    look(ka);
    step();
    fetch_PC = 29'h0;
    write_key(kc, 32'hC000_0003);
    look(kb);
    checks++;
    if (hit !== 1'b0 || {target, btype} !== 32'd0) begin
      errors++;
      $display("FAIL lru_evict_b: hit=%b data=%h, want 0/0", hit, {target, btype});
    end
    look(ka);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== 32'hA000_0001) begin
      errors++;
      $display("FAIL lru_keep_a: hit=%b data=%h, want 1/a0000001", hit, {target, btype});
    end
    look(kc);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== 32'hC000_0003) begin
      errors++;
      $display("FAIL lru_new_c: hit=%b data=%h, want 1/c0000003", hit, {target, btype});
    end
  endtask

  task automatic test_rewrite();
    logic [28:0] ka, kc;
    ka = {25'h1, 4'h5};
    kc = {25'h3, 4'h5};
    // Touch A so the LRU points at C's way; a non-in-place write would evict C.
    look(ka);
    step();
    fetch_PC = 29'h0;
    write_key(ka, 32'hDEAD_BEEF);
    look(ka);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rewrite_a: hit=%b data=%h, want 1/deadbeef", hit, {target, btype});
    end
    look(kc);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== 32'hC000_0003) begin
      errors++;
      $display("FAIL rewrite_keep_c: hit=%b data=%h, want 1/c0000003", hit, {target, btype});
    end
  endtask

  task automatic test_same_set_priority();
    logic [28:0] kx, ky, kw;
    kx = {25'h10, 4'h7};
    ky = {25'h20, 4'h7};
    kw = {25'h30, 4'h7};
    fetch_PC = 29'h0;
    write_key(kx, 32'h1111_1111);
    write_key(ky, 32'h2222_2222);
    // Lookup of X would make way 1 LRU; the in-place write of Y must win, leaving X LRU.
    fetch_PC = kx;
    write_key(ky, 32'h2222_3333);
    fetch_PC = 29'h0;
    write_key(kw, 32'h4444_4444);
    look(kx);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL prio_evict_x: hit=%b, want 0", hit);
    end
    look(ky);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== 32'h2222_3333) begin
      errors++;
      $display("FAIL prio_keep_y: hit=%b data=%h, want 1/22223333", hit, {target, btype});
    end
    look(kw);
    checks++;
    if (hit !== 1'b1 || {target, btype} !== 32'h4444_4444) begin
      errors++;
      $display("FAIL prio_new_w: hit=%b data=%h, want 1/44444444", hit, {target, btype});
    end
  endtask

  task automatic test_reset_with_load();
    logic [28:0] kl;
    kl = {25'h55, 4'h3};
    new_PC                  = kl;
    {new_target, new_btype} = 32'h7777_7777;
    load = 1'b1;
    rst  = 1'b1;
    step();
    load = 1'b0;
    rst  = 1'b0;
    look(kl);
    checks++;
    if (hit !== 1'b0 || {target, btype} !== 32'd0) begin
      errors++;
      $display("FAIL rst_load_key: hit=%b data=%h, want 0/0", hit, {target, btype});
    end
    look({25'h20, 4'h7});
    checks++;
    if (hit !== 1'b0 || {target, btype} !== 32'd0) begin
      errors++;
      $display("FAIL rst_load_old: hit=%b data=%h, want 0/0", hit, {target, btype});
    end
    look({25'h1, 4'h5});
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_load_a: hit=%b, want 0", hit);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_lru_evict();
    test_rewrite();
    test_same_set_priority();
    test_reset_with_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
